subtractor_64_seq: RTL
======================

Name: subtractor_64_seq

Overview:
- Multi-cycle 64-bit subtractor: computes A - B with ARM-style carry-in (result = A + ~B + carryin), processing SLICE bits per cycle.
- Produces LEGv8 condition flags N, Z, V and C.
- Used as the datapath's SUBS/CMP/SBC engine alongside the combinational 64-bit adder.
- Valid/ready handshakes on both the operand side and the result side.

Parameters:
- WIDTH, 64: operand/result width.
- SLICE, 8: bits processed per BUSY cycle. WIDTH % SLICE must be 0; otherwise elaboration fails with $error.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands A, B, carryin are valid.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- carryin  input  1  ARM carry: 1 = no borrow-in, 0 = borrow 1.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  A + ~B + carryin, modulo 2^WIDTH.
- carryout  output  1  C flag: carry out of the MSB (1 = no borrow).
- negative  output  1  N flag = result[WIDTH-1].
- zero  output  1  Z flag: result == 0.
- overflow  output  1  V flag = (A[MSB] != B[MSB]) && (result[MSB] != A[MSB]).

Behaviour:
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Reset (reset=0, asynchronous):
  - state=IDLE, slice counter=0, internal carry=0.
  - result=0; carryout, negative, zero, overflow=0; out_valid=0.
  - in_ready=1 (IDLE).
- IDLE -> BUSY on an edge with in_valid && in_ready. At that edge:
  - latch A, B and ~B copies.
  - internal carry register <= carryin.
  - slice counter <= 0.
  - in_valid is ignored outside IDLE.
- BUSY, each edge, with k = counter:
  - slice k (bits k*SLICE+SLICE-1 .. k*SLICE) = A_slice + ~B_slice + carry.
  - slice sum written into a working register; carry register <= slice carry-out; counter++.
- After slice N-1, where N = WIDTH/SLICE:
  - transition to DONE.
  - result, carryout, negative, zero and overflow are loaded from the working register and final carry on that same edge.
- Latency: with accept at edge 0, out_valid rises after edge N (8 for defaults). The working register is never visible on result.
- DONE:
  - result and flags held stable while out_valid && !out_ready.
  - on an edge with out_ready=1: -> IDLE, out_valid=0.
  - result and flags keep their last values until the next DONE load (they are not cleared).
  - no new operand is accepted in the same edge as the result handoff; the earliest next accept is the edge after returning to IDLE.
- Carry chain: the carry propagates across slice boundaries through the carry register only. There is no combinational path from slice k to slice k+1 within a cycle.
- Flags are computed on the full WIDTH-bit result, never per slice.
- Reset asserted mid-BUSY or in DONE:
  - aborts the operation immediately and all outputs take their reset values.
  - after deassertion the block behaves as fresh (IDLE, in_ready=1).
- out_ready is ignored outside DONE.

Test Plan:
- A=5, B=3, carryin=1 -> result=0x2, carryout=1, N=0, Z=0, V=0; out_valid rises exactly 8 edges after accept.
- Borrow chain: A=0x0000000100000000, B=1, carryin=1 -> result=0x00000000FFFFFFFF, C=1, N=0, Z=0, V=0. Separately A=0, B=1, carryin=1 -> result=0xFFFFFFFFFFFFFFFF, C=0, N=1, V=0.
- Signed overflow: A=0x8000000000000000, B=1, carryin=1 -> result=0x7FFFFFFFFFFFFFFF, V=1, C=1, N=0, Z=0.
- Equal operands: A=B=0x123456789ABCDEF0 with carryin=1 -> result=0, Z=1, C=1. Same operands with carryin=0 -> result=0xFFFFFFFFFFFFFFFF, Z=0, C=0, N=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid with new operands. Required:
  - out_valid stays 1 and in_ready stays 0.
  - result and flags are unchanged and the new operands are ignored.
  - on out_ready=1 the block returns to IDLE; the next operation is accepted no earlier than the following edge.
- Reset mid-operation: start A=5, B=3 and pull reset low during the 3rd BUSY cycle. Required:
  - all outputs go to 0 asynchronously and in_ready=1 after release.
  - a following A=10, B=4, carryin=1 yields result=6, C=1, Z=0.

Source files
------------

// File: rtl/subtractor_64_seq_if.sv
// rtl/subtractor_64_seq_if.sv - operand/result handshake bundle for the sequential subtractor
interface subtractor_64_seq_if #(
  parameter int WIDTH = 64
);
  // operand side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             carryin;
  // result side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carryout;
  logic             negative;
  logic             zero;
  logic             overflow;

  // producer of operands / consumer of results
  modport master (
    output in_valid, A, B, carryin, out_ready,
    input  in_ready, out_valid, result, carryout, negative, zero, overflow
  );

  // the subtractor itself
  modport slave (
    input  in_valid, A, B, carryin, out_ready,
    output in_ready, out_valid, result, carryout, negative, zero, overflow
  );
endinterface

// File: rtl/subtractor_64_seq.sv
// rtl/subtractor_64_seq.sv - multi-cycle A + ~B + carryin subtractor with N/Z/V/C flags
module subtractor_64_seq #(
  parameter int WIDTH = 64,
  parameter int SLICE = 8
) (
  input  logic                clk,
  input  logic                reset,
  subtractor_64_seq_if.slave  bus
);

  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam int SW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (WIDTH % SLICE != 0) begin : g_bad_slice
    $error("subtractor_64_seq: WIDTH must be a multiple of SLICE");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] nb_q, nb_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             c_q, c_d;
  logic             n_q, n_d;
  logic             z_q, z_d;
  logic             v_q, v_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [SW-1:0]    base;
  logic [SLICE:0]   sl_sum;

  // Next-state logic: one slice of A + ~B + carry per BUSY cycle, carry held in carry_q between slices
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_d         = a_q;
    nb_d        = nb_q;
    work_d      = work_q;
    result_d    = result_q;
    c_d         = c_q;
    n_d         = n_q;
    z_d         = z_q;
    v_d         = v_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    base   = SW'(cnt_q) * SW'(SLICE);
    sl_sum = {1'b0, a_q[base +: SLICE]} + {1'b0, nb_q[base +: SLICE]}
           + {{SLICE{1'b0}}, carry_q};

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_d        = bus.A;
          nb_d       = ~bus.B;
          carry_d    = bus.carryin;
          cnt_d      = '0;
          state_d    = S_BUSY;
          in_ready_d = 1'b0;
        end
      end
      S_BUSY: begin
        work_d[base +: SLICE] = sl_sum[SLICE-1:0];
        carry_d               = sl_sum[SLICE];
        cnt_d                 = cnt_q + CW'(1);
        if (cnt_q == CW'(NSL - 1)) begin
          // Final slice: publish the full-width result and flags on this same edge
          state_d     = S_DONE;
          result_d    = work_d;
          c_d         = sl_sum[SLICE];
          n_d         = work_d[WIDTH-1];
          z_d         = (work_d == '0);
          // A and B signs differ exactly when A's sign equals ~B's sign
          v_d         = (a_q[WIDTH-1] == nb_q[WIDTH-1]) && (work_d[WIDTH-1] != a_q[WIDTH-1]);
          out_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        // Handoff returns to IDLE only; the next accept needs in_ready to be seen high first
        if (bus.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      nb_q        <= '0;
      work_q      <= '0;
      result_q    <= '0;
      c_q         <= 1'b0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      v_q         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      nb_q        <= nb_d;
      work_q      <= work_d;
      result_q    <= result_d;
      c_q         <= c_d;
      n_q         <= n_d;
      z_q         <= z_d;
      v_q         <= v_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.carryout  = c_q;
  assign bus.negative  = n_q;
  assign bus.zero      = z_q;
  assign bus.overflow  = v_q;

endmodule
